// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard detection for a 5-stage MIPS-style core.
//
// Decides each cycle whether the instruction in ID must be held. Two causes:
//   - data hazard: an ID source register is written by the EX or MEM
//     instruction, and that result is not ready in time (Tuse < Tnew);
//   - mult/div hazard: the ID instruction touches HI/LO while the
//     multiply/divide unit is busy or is being started from EX.
// On a stall the PC and IF/ID register hold and ID/EX is flushed to a bubble.
//
// Parameters:
//   MULT_CYC  busy duration of mult/multu in cycles (default 5, max 15)
//   DIV_CYC   busy duration of div/divu in cycles   (default 10, max 15)
//
// Ports:
//   clk                    clock, all state updates on posedge
//   reset                  synchronous active-low reset
//   D_rs, D_rt             ID source register numbers
//   D_Tuse_rs, D_Tuse_rt   cycles until ID needs rs/rt (3 = never used)
//   D_md_use               ID instruction uses the mult/div unit or HI/LO
//   E_wa, M_wa             EX/MEM destination register (0 = none)
//   E_Tnew, M_Tnew         cycles until EX/MEM result is forwardable
//   E_md_start             EX holds mult/multu/div/divu
//   E_md_is_div            qualifies E_md_start: 1 = div/divu
//   PC_EN, ID_EN           PC / IF-ID write enables (low on stall)
//   EX_FLUSH               bubble into ID/EX (high on stall)
//   md_busy                mult/div unit busy (from the countdown register)
//   stall_cnt              stalled-cycle count
//
// Build option: define HAZARD_STALL_CNT_EN to instantiate the saturating
// stall counter; otherwise stall_cnt is tied to zero.

module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_md_use,
  input  logic [4:0]  E_wa,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        PC_EN,
  output logic        ID_EN,
  output logic        EX_FLUSH,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  logic       stall_rs;
  logic       stall_rt;
  logic       md_stall;
  logic       stall;
  logic [3:0] md_cnt_q;
  logic [3:0] md_cnt_d;

  assign md_busy = (md_cnt_q != 4'd0);

  // Register $0 is hard-wired zero, so it never creates a dependency.
  // Tuse=3 can never be below a Tnew of at most 2, so it needs no special case.
  always_comb begin
    stall_rs = (D_rs != 5'd0) &&
               (((D_rs == E_wa) && (D_Tuse_rs < E_Tnew)) ||
                ((D_rs == M_wa) && (D_Tuse_rs < M_Tnew)));
    stall_rt = (D_rt != 5'd0) &&
               (((D_rt == E_wa) && (D_Tuse_rt < E_Tnew)) ||
                ((D_rt == M_wa) && (D_Tuse_rt < M_Tnew)));
    md_stall = D_md_use && (md_busy || E_md_start);
    stall    = stall_rs || stall_rt || md_stall;
    PC_EN    = !stall;
    ID_EN    = !stall;
    EX_FLUSH = stall;
  end

  // A start while the unit is already counting is ignored; the running
  // operation keeps its original completion time.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (E_md_start && (md_cnt_q == 4'd0)) begin
      md_cnt_d = E_md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_wa, M_wa;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_md_use, E_md_start, E_md_is_div;
  logic        PC_EN, ID_EN, EX_FLUSH, md_busy;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state: remaining busy cycles and stall count.
  int          busy_left = 0;
  logic [31:0] ref_cnt   = 32'd0;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_md_use(D_md_use), .E_wa(E_wa), .M_wa(M_wa), .E_Tnew(E_Tnew),
    .M_Tnew(M_Tnew), .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .PC_EN(PC_EN), .ID_EN(ID_EN), .EX_FLUSH(EX_FLUSH), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit src_hazard(input int r, input int tuse);
    if (r == 0) return 0;
    if (r == int'(E_wa) && tuse < int'(E_Tnew)) return 1;
    if (r == int'(M_wa) && tuse < int'(M_Tnew)) return 1;
    return 0;
  endfunction

  function automatic bit ref_stall();
    bit md;
    md = D_md_use && (busy_left > 0 || E_md_start);
    return src_hazard(int'(D_rs), int'(D_Tuse_rs)) ||
           src_hazard(int'(D_rt), int'(D_Tuse_rt)) || md;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 3; D_Tuse_rt = 3; D_md_use = 0;
    E_wa = 0; M_wa = 0; E_Tnew = 0; M_Tnew = 0;
    E_md_start = 0; E_md_is_div = 0;
  endtask

  // Check all outputs against the model mid-cycle, then advance one edge.
  task automatic cycle(input string tag);
    bit s;
    @(negedge clk);
    s = ref_stall();
    chk({tag, ".pc_en"},    {31'd0, PC_EN},    {31'd0, !s});
    chk({tag, ".id_en"},    {31'd0, ID_EN},    {31'd0, !s});
    chk({tag, ".ex_flush"}, {31'd0, EX_FLUSH}, {31'd0, s});
    chk({tag, ".md_busy"},  {31'd0, md_busy},  {31'd0, busy_left > 0});
`ifdef HAZARD_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, ref_cnt);
`else
    chk({tag, ".stall_cnt"}, stall_cnt, 32'd0);
`endif
    @(posedge clk);
    if (!reset) begin
      busy_left = 0;
      ref_cnt   = 32'd0;
    end else begin
      if (E_md_start && busy_left == 0) busy_left = E_md_is_div ? 10 : 5;
      else if (busy_left > 0) busy_left--;
`ifdef HAZARD_STALL_CNT_EN
      if (s && ref_cnt != 32'hFFFF_FFFF) ref_cnt++;
`endif
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    // Reset state
    repeat (3) cycle("reset");
    reset = 1'b1;
    cycle("idle");

    // EX load-use on rs: Tuse 0 < Tnew 1 stalls, Tuse 1 does not
    D_rs = 5; D_Tuse_rs = 0; E_wa = 5; E_Tnew = 1;
    @(negedge clk);
    chk("rs_hazard.direct", {31'd0, EX_FLUSH}, 32'd1);
    cycle("rs_hazard");
    D_Tuse_rs = 1;
    @(negedge clk);
    chk("rs_ok.direct", {31'd0, PC_EN}, 32'd1);
    cycle("rs_ok");

    // $0 never stalls; rt hazard from MEM
    clear_inputs();
    D_rs = 0; E_wa = 0; E_Tnew = 2; D_Tuse_rs = 0;
    cycle("zero_reg");
    D_rt = 7; M_wa = 7; M_Tnew = 1; D_Tuse_rt = 0;
    cycle("rt_mem");
    D_rt = 7; M_wa = 7; M_Tnew = 2; D_Tuse_rt = 3;
    cycle("tuse3");

    // Mult: one-cycle start, D_md_use held for the whole window
    clear_inputs();
    D_md_use = 1; E_md_start = 1; E_md_is_div = 0;
    cycle("mult_start");
    E_md_start = 0;
    repeat (6) cycle("mult_busy");
    D_md_use = 0;

    // Div with a second start on busy cycle 3 (ignored)
    E_md_start = 1; E_md_is_div = 1;
    cycle("div_start");
    E_md_start = 0;
    repeat (2) cycle("div_busy");
    E_md_start = 1; E_md_is_div = 0;
    cycle("div_restart");
    E_md_start = 0;
    repeat (8) cycle("div_tail");

    // Div aborted by reset on busy cycle 4
    E_md_start = 1; E_md_is_div = 1;
    cycle("div2_start");
    E_md_start = 0;
    repeat (3) cycle("div2_busy");
    reset = 1'b0;
    cycle("div2_reset");
    reset = 1'b1;
    chk("div2_after_reset.md_busy", {31'd0, md_busy}, 32'd0);
    chk("div2_after_reset.cnt", stall_cnt, 32'd0);
    cycle("div2_post");

    // Seven stall cycles from a cleared counter
    D_rs = 9; D_Tuse_rs = 0; E_wa = 9; E_Tnew = 2;
    repeat (7) cycle("hold_stall");
    clear_inputs();
    @(negedge clk);
`ifdef HAZARD_STALL_CNT_EN
    chk("stall7.cnt", stall_cnt, 32'd7);
    // Saturation at all-ones
    D_rs = 9; D_Tuse_rs = 0; E_wa = 9; E_Tnew = 2;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    ref_cnt = 32'hFFFF_FFFF;
    cycle("sat");
    clear_inputs();
    cycle("sat_after");
    chk("sat.cnt", stall_cnt, 32'hFFFF_FFFF);
`else
    chk("stall7.cnt", stall_cnt, 32'd0);
`endif

    // Randomized traffic against the model
    reset = 1'b0;
    cycle("rand_reset");
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      D_rs        = 5'($urandom_range(0, 7));
      D_rt        = 5'($urandom_range(0, 7));
      D_Tuse_rs   = 2'($urandom_range(0, 3));
      D_Tuse_rt   = 2'($urandom_range(0, 3));
      D_md_use    = ($urandom_range(0, 3) == 0);
      E_wa        = 5'($urandom_range(0, 7));
      M_wa        = 5'($urandom_range(0, 7));
      E_Tnew      = 2'($urandom_range(0, 2));
      M_Tnew      = 2'($urandom_range(0, 2));
      E_md_start  = ($urandom_range(0, 7) == 0);
      E_md_is_div = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 39) != 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYC, default 5, giving the mult/multu busy duration in cycles.
REQ-002 The block SHALL have parameter DIV_CYC, default 10, giving the div/divu busy duration in cycles.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset (reset==0 at posedge clk resets).
REQ-005 D_rs, D_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 D_Tuse_rs, D_Tuse_rt  in  2 each  cycles until ID instruction needs rs/rt (3 = never used).
REQ-007 D_md_use  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 E_wa, M_wa  in  5 each  destination register of the EX/MEM instruction (0 = none).
REQ-009 E_Tnew, M_Tnew  in  2 each  cycles until EX/MEM result becomes forwardable.
REQ-010 E_md_start  in  1  EX holds mult/multu/div/divu this cycle.
REQ-011 E_md_is_div  in  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu.
REQ-012 PC_EN  out  1  PC write enable.
REQ-013 ID_EN  out  1  IF/ID pipeline register write enable.
REQ-014 EX_FLUSH  out  1  clears ID/EX register to a bubble next edge.
REQ-015 md_busy  out  1  multiply/divide unit busy (registered).
REQ-016 stall_cnt  out  32  count of stalled cycles.

Function
REQ-017 stall_rs SHALL be 1 iff D_rs!=0 and ((D_rs==E_wa and D_Tuse_rs<E_Tnew) or (D_rs==M_wa and D_Tuse_rs<M_Tnew)); stall_rt SHALL be defined identically on D_rt/D_Tuse_rt.
REQ-018 md_stall SHALL be 1 iff D_md_use and (md_busy or E_md_start).
REQ-019 stall SHALL be stall_rs | stall_rt | md_stall, combinational, same cycle as its inputs.
REQ-020 PC_EN and ID_EN SHALL equal ~stall; EX_FLUSH SHALL equal stall.
REQ-021 A 4-bit down-counter md_cnt SHALL load MULT_CYC (E_md_is_div=0) or DIV_CYC (E_md_is_div=1) at the edge where E_md_start=1 and md_cnt==0.
REQ-022 When md_cnt!=0 and no load occurs, md_cnt SHALL decrement by 1 per cycle, stopping at 0.
REQ-023 E_md_start while md_cnt!=0 SHALL be ignored (no reload); md_cnt continues decrementing.
REQ-024 md_busy SHALL be (md_cnt!=0): asserted the cycle after the start edge, for exactly MULT_CYC or DIV_CYC cycles.
REQ-025 Register $0 SHALL never cause a stall, regardless of E_wa/M_wa values.
REQ-026 Tuse=3 SHALL never cause a data stall (Tnew is at most 2).

Reset
REQ-027 On reset==0 at posedge clk: md_cnt=0, md_busy=0, stall_cnt=0; this SHALL abort any in-progress mult/div countdown.
REQ-028 PC_EN, ID_EN, EX_FLUSH SHALL remain purely combinational of current inputs and md_busy during and after reset.

Configuration
REQ-029 With macro HAZARD_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 each cycle stall=1 (reset==1), saturating at 32'hFFFFFFFF.
REQ-030 Without HAZARD_STALL_CNT_EN, stall_cnt port SHALL exist and be tied to 32'd0 with no counter register instantiated.

Verification
REQ-031 D_rs=5, D_Tuse_rs=0, E_wa=5, E_Tnew=1 -> stall=1: PC_EN=0, ID_EN=0, EX_FLUSH=1 same cycle; with D_Tuse_rs=1 -> stall=0.
REQ-032 D_rs=0, E_wa=0, E_Tnew=2, D_Tuse_rs=0 -> no stall; D_rt=7, M_wa=7, M_Tnew=1, D_Tuse_rt=0 -> stall=1.
REQ-033 E_md_start=1, E_md_is_div=0 for one cycle -> md_busy=1 for exactly 5 following cycles; D_md_use=1 throughout -> stall=1 in start cycle and all 5 busy cycles, 0 after.
REQ-034 Div start (E_md_is_div=1), second E_md_start at busy cycle 3 -> md_busy still drops after exactly 10 cycles from first start.
REQ-035 Div start, reset=0 at busy cycle 4 -> md_busy=0 next cycle, stall_cnt=0.
REQ-036 With HAZARD_STALL_CNT_EN: hold stall=1 for 7 cycles -> stall_cnt=7; preload-by-force 32'hFFFFFFFF plus 1 stall cycle -> stays 32'hFFFFFFFF; without macro -> stall_cnt=0 always.
